xorshift_seq: RTL



---
 rtl/pseudorand_pkg.sv | 29 ++
 rtl/xs_stage.sv | 27 ++
 rtl/xorshift_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pseudorand_pkg.sv
// ---------------------------------------------------------------------------
// pseudorand_pkg
//   Shared definitions for the PSEUDORAND xorshift datapath: the sequencer
//   state encoding, the 16-bit data word type, the default seed and the
//   default shift triple (7, 9, 8).
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pseudorand_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STEP_A = 3'd1,
    STEP_B = 3'd2,
    STEP_C = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam word_t C_DEFAULT_SEED = 16'hACE1;
  localparam int    C_SHL_A        = 7;
  localparam int    C_SHR_B        = 9;
  localparam int    C_SHL_C        = 8;

endpackage

`default_nettype wire

// File: rtl/xs_stage.sv
// ---------------------------------------------------------------------------
// xs_stage
//   One xorshift step, purely combinational: y = x ^ (x shifted by amt).
//   Shifts are 16 bits wide and zero-fill; bits shifted out are lost.
//   Ports:
//     x_i   [15:0]  operand
//     amt_i [3:0]   shift amount
//     dir_i         0 = shift left, 1 = logical shift right
//     y_o   [15:0]  x ^ (x shifted)
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module xs_stage
  import pseudorand_pkg::*;
(
  input  word_t      x_i,
  input  logic [3:0] amt_i,
  input  logic       dir_i,
  output word_t      y_o
);

  assign y_o = dir_i ? (x_i ^ (x_i >> amt_i)) : (x_i ^ (x_i << amt_i));

endmodule

`default_nettype wire

// File: rtl/xorshift_seq.sv
// ---------------------------------------------------------------------------
// xorshift_seq
//   Sequencing controller for the 16-bit xorshift generator. Holds the state
//   word X and runs X^=X<<A, X^=X>>B, X^=X<<C over three cycles through one
//   shared xs_stage, then presents the result with a one-cycle rnd_valid.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     seed_load        load seed_in into X (zero replaced by DEFAULT_SEED);
//                      aborts any sequence, highest priority
//     seed_in  [15:0]  seed value
//     req              request a new word; accepted while ready=1
//     ready            high in IDLE or DONE
//     busy             high in STEP_A/STEP_B/STEP_C
//     rnd_valid        one-cycle pulse in DONE
//     rnd_out  [15:0]  last generated word, held until the next DONE
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module xorshift_seq
  import pseudorand_pkg::*;
#(
  parameter int    SHL_A        = C_SHL_A,
  parameter int    SHR_B        = C_SHR_B,
  parameter int    SHL_C        = C_SHL_C,
  parameter word_t DEFAULT_SEED = C_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        req,
  output logic        ready,
  output logic        busy,
  output logic        rnd_valid,
  output logic [15:0] rnd_out
);

  localparam logic [3:0] C_AMT_A = 4'(SHL_A);
  localparam logic [3:0] C_AMT_B = 4'(SHR_B);
  localparam logic [3:0] C_AMT_C = 4'(SHL_C);

  state_e     state_q, state_d;
  word_t      x_q, x_d;
  word_t      rnd_q, rnd_d;
  logic [3:0] stage_amt;
  logic       stage_dir;
  word_t      stage_y;

  // The single shift/XOR stage is steered by the current step.
  always_comb begin
    stage_amt = C_AMT_A;
    stage_dir = 1'b0;
    case (state_q)
      STEP_B: begin
        stage_amt = C_AMT_B;
        stage_dir = 1'b1;
      end
      STEP_C: begin
        stage_amt = C_AMT_C;
        stage_dir = 1'b0;
      end
      default: begin
        stage_amt = C_AMT_A;
        stage_dir = 1'b0;
      end
    endcase
  end

  xs_stage u_xs_stage (
    .x_i   (x_q),
    .amt_i (stage_amt),
    .dir_i (stage_dir),
    .y_o   (stage_y)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rnd_d   = rnd_q;
    if (seed_load) begin
      // A zero seed would lock the generator at zero forever, since every
      // xorshift step is invertible and maps 0 to 0.
      state_d = IDLE;
      x_d     = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) state_d = STEP_A;
        end
        STEP_A: begin
          x_d     = stage_y;
          state_d = STEP_B;
        end
        STEP_B: begin
          x_d     = stage_y;
          state_d = STEP_C;
        end
        STEP_C: begin
          x_d     = stage_y;
          rnd_d   = stage_y;
          state_d = DONE;
        end
        DONE: begin
          state_d = req ? STEP_A : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= DEFAULT_SEED;
      rnd_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rnd_q   <= rnd_d;
    end
  end

  // Status outputs are pure decodes of the state register.
  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign busy      = (state_q == STEP_A) || (state_q == STEP_B) || (state_q == STEP_C);
  assign rnd_valid = (state_q == DONE);
  assign rnd_out   = rnd_q;

endmodule

`default_nettype wire
